// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer for the single-cycle ALU op units; owns the N/Z/C flag register.
// Optional build macro ALU_B2B_EN: accept a new request in the same cycle as the writeback handshake.
module alu_issue_ctrl #(
  parameter int NUM_OPS  = 4,
  parameter int OP_W     = 2,
  parameter int EXEC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OP_W-1:0]         req_op,
  input  logic                    req_s,
  input  logic [3:0]              req_rd,
  output logic [NUM_OPS-1:0]      op_en,
  input  logic [32*NUM_OPS-1:0]   op_res,
  input  logic [NUM_OPS-1:0]      op_c,
  input  logic [NUM_OPS-1:0]      op_z,
  input  logic [NUM_OPS-1:0]      op_n,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic                    flag_n,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [31:0]             wb_data,
  output logic [3:0]              wb_rd,
  output logic                    wb_err,
  output logic                    busy
);

  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [OP_W-1:0] op);
    logic [NUM_OPS-1:0] v;
    for (int k = 0; k < NUM_OPS; k++) begin
      v[k] = (op == OP_W'(k));
    end
    return v;
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return ({{(32-OP_W){1'b0}}, op} < 32'(NUM_OPS));
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [OP_W-1:0]      op_r;
  logic                 s_r;
  logic [3:0]           rd_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_OPS-1:0]   op_en_r;
  logic                 wb_valid_r;
  logic                 busy_r;
  logic                 req_ready_r;
  logic [31:0]          wb_data_r;
  logic [3:0]           wb_rd_r;
  logic                 wb_err_r;
  logic                 flag_c_r;
  logic                 flag_z_r;
  logic                 flag_n_r;
  logic                 accept_s;
  logic                 capture_s;
  logic                 illegal_s;
  logic [NUM_OPS-1:0]   sel_oh_s;
  logic [31:0]          res_sel_s;
  logic                 c_sel_s;
  logic                 z_sel_s;
  logic                 n_sel_s;

  assign sel_oh_s = op_onehot(op_r);

  // Next-state decode and the accept/capture/illegal strobes for this cycle
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    illegal_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!op_legal(op_r)) begin
          illegal_s   = 1'b1;
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
`ifdef ALU_B2B_EN
          if (req_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
`else
          state_nxt_s = ST_IDLE;
`endif
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Select the active unit's result and flag outputs with a one-hot AND-OR mux
  always_comb begin
    res_sel_s = 32'h0000_0000;
    c_sel_s   = 1'b0;
    z_sel_s   = 1'b0;
    n_sel_s   = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      res_sel_s = res_sel_s | (op_res[32*k +: 32] & {32{sel_oh_s[k]}});
      c_sel_s   = c_sel_s | (op_c[k] & sel_oh_s[k]);
      z_sel_s   = z_sel_s | (op_z[k] & sel_oh_s[k]);
      n_sel_s   = n_sel_s | (op_n[k] & sel_oh_s[k]);
    end
  end

  // Control state, latched request, execute counter and the registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      op_r        <= {OP_W{1'b0}};
      s_r         <= 1'b0;
      rd_r        <= 4'h0;
      cnt_r       <= {CNT_W{1'b0}};
      op_en_r     <= {NUM_OPS{1'b0}};
      wb_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      wb_valid_r  <= (state_nxt_s == ST_WB);
      busy_r      <= (state_nxt_s != ST_IDLE);
      req_ready_r <= (state_nxt_s == ST_IDLE);
      if (accept_s) begin
        op_r <= req_op;
        s_r  <= req_s;
        rd_r <= req_rd;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= CNT_W'(EXEC_LAT - 1);
      end else if ((state_r == ST_EXEC) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      // Enable rises on the accept edge so it is high for all of ISSUE; an illegal op yields zero
      if (accept_s) begin
        op_en_r <= op_onehot(req_op);
      end else if (capture_s) begin
        op_en_r <= {NUM_OPS{1'b0}};
      end
    end
  end

  // Writeback payload, captured at the end of EXEC or forced to an error for an illegal op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_r <= 32'h0000_0000;
      wb_rd_r   <= 4'h0;
      wb_err_r  <= 1'b0;
    end else if (capture_s) begin
      wb_data_r <= res_sel_s;
      wb_rd_r   <= rd_r;
      wb_err_r  <= 1'b0;
    end else if (illegal_s) begin
      wb_data_r <= 32'h0000_0000;
      wb_rd_r   <= rd_r;
      wb_err_r  <= 1'b1;
    end
  end

  // Architectural flags, written only at the capture edge of a flag-setting op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (capture_s && s_r) begin
      flag_c_r <= c_sel_s;
      flag_z_r <= z_sel_s;
      flag_n_r <= n_sel_s;
    end
  end

`ifdef ALU_B2B_EN
  assign req_ready = req_ready_r | (wb_valid_r & wb_ready);
`else
  assign req_ready = req_ready_r;
`endif

  assign op_en    = op_en_r;
  assign wb_valid = wb_valid_r;
  assign wb_data  = wb_data_r;
  assign wb_rd    = wb_rd_r;
  assign wb_err   = wb_err_r;
  assign busy     = busy_r;
  assign flag_c   = flag_c_r;
  assign flag_z   = flag_z_r;
  assign flag_n   = flag_n_r;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue sequencer for the single-cycle logical/arith op units (op_xor and siblings) in the Cortex-M0 execute stage. Accepts one decoded data-processing request at a time and raises the selected unit's one-hot en_inst. It holds the enable through a fixed execute window, then captures Rd and the NZC outputs. It owns the architectural N/Z/C flag register, feeds it back as carry_in/zero_in/neg_in, and presents the result to writeback over a valid/ready handshake.

Parameters:
NUM_OPS, 4, number of op units sharing the sequencer (one en_inst each)
OP_W, 2, width of op select; NUM_OPS <= 2**OP_W
EXEC_LAT, 1, cycles en_inst is held in EXEC before capture (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  decoded request present
req_ready  out  1  sequencer can accept request
req_op  in  OP_W  op unit select
req_s  in  1  update flags on completion
req_rd  in  4  destination register index
op_en  out  NUM_OPS  one-hot en_inst to op units
op_res  in  32*NUM_OPS  concatenated Rd outputs, unit k at [32k+31:32k]
op_c  in  NUM_OPS  carry_out per unit
op_z  in  NUM_OPS  zero_out per unit
op_n  in  NUM_OPS  neg_out per unit
flag_c  out  1  architectural C (to units' carry_in)
flag_z  out  1  architectural Z (to zero_in)
flag_n  out  1  architectural N (to neg_in)
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_data  out  32  captured result
wb_rd  out  4  captured destination index
wb_err  out  1  request had illegal op select
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; op_en=0; wb_valid=0; wb_data=0; wb_rd=0; wb_err=0; flag_c=flag_z=flag_n=0; internal counter=0. Mid-operation reset aborts with no flag update.
- States: IDLE, ISSUE, EXEC, WB.
- IDLE: req_ready=1. On req_valid: latch op, s, rd → ISSUE.
- ISSUE (1 cycle): op_en[op]=1 (rising edge to unit); counter=EXEC_LAT-1 → EXEC. If op>=NUM_OPS: op_en stays 0, go directly to WB with wb_data=0, wb_err=1, flags unchanged.
- EXEC: op_en[op] held high; counter decrements each cycle. On the cycle counter==0: capture wb_data=op_res[op]; wb_rd=rd; wb_err=0; if s then flags ← {op_n[op],op_z[op],op_c[op]}; op_en→0; → WB.
- Latency: request accepted at edge T → op_en high T+1..T+1+EXEC_LAT → wb_valid high from cycle T+2+EXEC_LAT.
- WB: wb_valid=1, wb_data/wb_rd/wb_err stable until wb_ready. On wb_ready: → IDLE (base build). Without wb_ready: hold indefinitely.
- req_ready=0 outside IDLE (base build); req_valid then ignored, not latched.
- op_en is at most one-hot, always 0 outside ISSUE/EXEC; falls to 0 for ≥1 cycle between requests (units trigger on the en edge).
- Flags change only at the EXEC capture edge; they are stable during ISSUE/EXEC.

Optional Feature:
ALU_B2B_EN: when defined, in WB with wb_ready=1, req_ready=1. A simultaneous req_valid latches the new request and goes directly to ISSUE (back-to-back, one op per EXEC_LAT+2 cycles). op_en has already been low during WB, so the edge requirement holds. When undefined, WB always returns to IDLE and the next accept occurs ≥1 cycle later.

Test Plan:
- Reset mid-EXEC with op_en[2]=1 → op_en=0, wb_valid=0, flags 0 immediately, state IDLE.
- req op=1, s=1, rd=5; unit1 returns res=0x0000_0000, z=1, n=0, c=1 → wb_valid at T+3 (EXEC_LAT=1), wb_data=0, wb_rd=5, flag_z=1, flag_c=1, op_en=4'b0010 for exactly 2 cycles.
- Same with s=0, res=0x8000_0000, n=1 → wb_data=0x8000_0000, flags unchanged from the previous test.
- Illegal op (NUM_OPS=3, op=3) → op_en never asserted, wb_err=1, wb_data=0, flags unchanged.
- wb_ready held low 5 cycles with a new req_valid=1 → wb_data stable, req_ready=0, second request accepted only after the handshake (cycle after, or same edge with ALU_B2B_EN).
- EXEC_LAT=3 → op_en held 4 cycles, wb_valid at T+5.
